// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC holder and req/ack instruction fetcher feeding the decoder.
// Optional misaligned-redirect trap: define MISALIGN_CHECK_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_read,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic        instr_valid,
    output logic        fetch_fault
);

`ifdef MISALIGN_CHECK_EN
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HALT  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_ISSUE = 2'd1
    } state_t;
`endif

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_instruction;
    logic [31:0] r_pc;
    logic        r_instr_valid;
    logic        w_redirect;
    logic        w_misaligned;
    logic [31:0] w_target;

    assign w_redirect = branch_taken && (r_state == ST_FETCH || r_state == ST_ISSUE);
    assign w_target   = {branch_target[31:2], 2'b00};

`ifdef MISALIGN_CHECK_EN
    logic r_fault;
    assign w_misaligned = branch_target[1:0] != 2'b00;
    assign fetch_fault  = r_fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else if (w_redirect && w_misaligned) begin
            r_fault <= 1'b1;
        end
    end
`else
    logic w_unused_tgt_lo;
    assign w_unused_tgt_lo = ^branch_target[1:0];
    assign w_misaligned    = 1'b0;
    assign fetch_fault     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        mem_read     = 1'b0;
        case (r_state)
            ST_FETCH: begin
                mem_read = 1'b1;
                if (!branch_taken && mem_ack) begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!branch_taken && !stall) begin
                    w_next_state = ST_FETCH;
                end
            end
            default: begin
                w_next_state = r_state;
            end
        endcase
        if (w_redirect) begin
`ifdef MISALIGN_CHECK_EN
            w_next_state = w_misaligned ? ST_HALT : ST_FETCH;
`else
            w_next_state = ST_FETCH;
`endif
        end
    end

    // A redirect drops any word returning in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_instruction <= 32'h0000_0013;
            r_pc          <= RESET_PC;
            r_instr_valid <= 1'b0;
        end else if (w_redirect) begin
            r_instr_valid <= 1'b0;
            if (!w_misaligned) begin
                r_fetch_pc <= w_target;
            end
        end else if (r_state == ST_FETCH && mem_ack) begin
            r_instruction <= mem_rdata;
            r_pc          <= r_fetch_pc;
            r_fetch_pc    <= r_fetch_pc + 32'd4;
            r_instr_valid <= 1'b1;
        end else if (r_state == ST_ISSUE && !stall) begin
            r_instr_valid <= 1'b0;
        end
    end

    assign mem_addr    = r_fetch_pc;
    assign instruction = r_instruction;
    assign pc          = r_pc;
    assign instr_valid = r_instr_valid;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed vector bench for instr_fetch_unit.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        instr_valid;
    logic        fetch_fault;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        e_read;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_fault;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] D   = 32'h0020_81B3;
    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .instruction  (instruction),
        .pc           (pc),
        .instr_valid  (instr_valid),
        .fetch_fault  (fetch_fault)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic ack, input logic [31:0] rdata, input logic stl,
                       input logic br, input logic [31:0] tgt,
                       input logic e_read, input logic [31:0] e_addr, input logic e_valid,
                       input logic [31:0] e_pc, input logic [31:0] e_instr, input logic e_fault);
        vec_t v;
        v.ack = ack; v.rdata = rdata; v.stall = stl; v.br = br; v.tgt = tgt;
        v.e_read = e_read; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_pc = e_pc; v.e_instr = e_instr; v.e_fault = e_fault;
        vecs.push_back(v);
    endtask

    task automatic check_outputs(input string tag, input logic e_read, input logic [31:0] e_addr,
                                 input logic e_valid, input logic [31:0] e_pc,
                                 input logic [31:0] e_instr, input logic e_fault);
        check({tag, " mem_read"}, {31'd0, mem_read}, {31'd0, e_read});
        check({tag, " mem_addr"}, mem_addr, e_addr);
        check({tag, " instr_valid"}, {31'd0, instr_valid}, {31'd0, e_valid});
        check({tag, " pc"}, pc, e_pc);
        check({tag, " instruction"}, instruction, e_instr);
        check({tag, " fetch_fault"}, {31'd0, fetch_fault}, {31'd0, e_fault});
    endtask

    initial begin
        rst = 1'b1; mem_rdata = 32'h0; mem_ack = 1'b1; stall = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0;

        // Each vector: inputs for the cycle, outputs expected before its rising edge.
        add(1, D,            0, 0, 0,            1, 32'h0,        0, 32'h0,        NOP,          0);
        add(1, D,            0, 0, 0,            0, 32'h4,        1, 32'h0,        D,            0);
        add(1, D,            0, 0, 0,            1, 32'h4,        0, 32'h0,        D,            0);
        add(1, D,            1, 0, 0,            0, 32'h8,        1, 32'h4,        D,            0);
        add(1, D,            1, 0, 0,            0, 32'h8,        1, 32'h4,        D,            0);
        add(1, D,            1, 0, 0,            0, 32'h8,        1, 32'h4,        D,            0);
        add(1, D,            0, 0, 0,            0, 32'h8,        1, 32'h4,        D,            0);
        add(0, D,            0, 0, 0,            1, 32'h8,        0, 32'h4,        D,            0);
        add(0, D,            0, 0, 0,            1, 32'h8,        0, 32'h4,        D,            0);
        add(0, D,            0, 0, 0,            1, 32'h8,        0, 32'h4,        D,            0);
        add(0, D,            0, 0, 0,            1, 32'h8,        0, 32'h4,        D,            0);
        add(1, D,            0, 0, 0,            1, 32'h8,        0, 32'h4,        D,            0);
        add(0, D,            0, 0, 0,            0, 32'hC,        1, 32'h8,        D,            0);
        add(1, 32'hDEAD_BEEF, 0, 1, 32'h100,     1, 32'hC,        0, 32'h8,        D,            0);
        add(1, 32'h1111_1111, 0, 0, 0,           1, 32'h100,      0, 32'h8,        D,            0);
        add(0, 0,            1, 1, 32'hFFFF_FFFC, 0, 32'h104,     1, 32'h100,      32'h1111_1111, 0);
        add(1, 32'h2222_2222, 0, 0, 0,           1, 32'hFFFF_FFFC, 0, 32'h100,     32'h1111_1111, 0);
        add(1, 0,            0, 0, 0,            0, 32'h0,        1, 32'hFFFF_FFFC, 32'h2222_2222, 0);
        add(0, 0,            0, 0, 0,            1, 32'h0,        0, 32'hFFFF_FFFC, 32'h2222_2222, 0);
        add(0, 0,            0, 1, 32'h102,      1, 32'h0,        0, 32'hFFFF_FFFC, 32'h2222_2222, 0);
`ifdef MISALIGN_CHECK_EN
        add(0, 0,            0, 0, 0,            0, 32'h0,        0, 32'hFFFF_FFFC, 32'h2222_2222, 1);
        add(1, 32'h3333_3333, 0, 1, 32'h200,     0, 32'h0,        0, 32'hFFFF_FFFC, 32'h2222_2222, 1);
        add(1, 0,            1, 0, 0,            0, 32'h0,        0, 32'hFFFF_FFFC, 32'h2222_2222, 1);
`else
        add(0, 0,            0, 0, 0,            1, 32'h100,      0, 32'hFFFF_FFFC, 32'h2222_2222, 0);
        add(1, 32'h3333_3333, 0, 0, 0,           1, 32'h100,      0, 32'hFFFF_FFFC, 32'h2222_2222, 0);
        add(1, 0,            1, 0, 0,            0, 32'h104,      1, 32'h100,      32'h3333_3333, 0);
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            mem_ack       = vecs[i].ack;
            mem_rdata     = vecs[i].rdata;
            stall         = vecs[i].stall;
            branch_taken  = vecs[i].br;
            branch_target = vecs[i].tgt;
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].e_read, vecs[i].e_addr,
                          vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_fault);
            @(negedge clk);
        end

        // Reset with ack/redirect asserted must override everything and clear the fault.
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h4444_4444;
        branch_taken = 1'b1; branch_target = 32'h300; stall = 1'b0;
        @(negedge clk);
        rst = 1'b0; branch_taken = 1'b0; mem_ack = 1'b0;
        #1;
        check_outputs("post_rst", 1'b1, 32'h0, 1'b0, 32'h0, NOP, 1'b0);

        // Refetch from RESET_PC after reset.
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        @(negedge clk);
        mem_ack = 1'b0; stall = 1'b1;
        #1;
        check_outputs("refetch", 1'b0, 32'h4, 1'b1, 32'h0, 32'h5555_5555, 1'b0);

        // Release stall: next request appears the cycle after consumption.
        @(negedge clk);
        stall = 1'b0;
        @(negedge clk);
        #1;
        check_outputs("after_stall", 1'b1, 32'h4, 1'b0, 32'h0, 32'h5555_5555, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
